// File: rtl/j1708_rx_uart_bridge_if.sv
// J1708 receive-side handshakes and CPU UART transmit port, bundled.
// The bridge connects through master; the J1708 core / UART environment connects through slave.
interface j1708_rx_uart_bridge_if;
    logic       rx_message_new_byte;
    logic [7:0] rx_message_byte;
    logic       rx_message_byte_valid;
    logic       rx_message_byte_read;
    logic       rx_message_length_exist;
    logic [7:0] rx_message_length;
    logic       rx_message_length_valid;
    logic       rx_message_length_read;
    logic [7:0] uart_tx_data_in;
    logic       uart_tx_data_wr;
    logic       uart_tx_busy;

    modport master (
        input  rx_message_new_byte, rx_message_byte, rx_message_byte_valid,
        input  rx_message_length_exist, rx_message_length, rx_message_length_valid,
        input  uart_tx_busy,
        output rx_message_byte_read, rx_message_length_read,
        output uart_tx_data_in, uart_tx_data_wr
    );

    modport slave (
        output rx_message_new_byte, rx_message_byte, rx_message_byte_valid,
        output rx_message_length_exist, rx_message_length, rx_message_length_valid,
        output uart_tx_busy,
        input  rx_message_byte_read, rx_message_length_read,
        input  uart_tx_data_in, uart_tx_data_wr
    );
endinterface

// File: rtl/j1708_rx_uart_bridge.sv
// Buffers J1708 receive bytes in a FIFO and forwards each message to the CPU UART
// as a frame: SYNC_BYTE, LEN, then LEN data bytes.
module j1708_rx_uart_bridge #(
    parameter int         DEPTH     = 32,
    parameter int         AW        = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    j1708_rx_uart_bridge_if.master        bus,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [AW:0]                   fifo_level
);

    typedef enum logic {I_IDLE, I_WAIT} ingest_state_t;
    typedef enum logic [2:0] {E_IDLE, E_LREQ, E_LWAIT, E_DWAIT, E_SYNC, E_LEN, E_DATA} egress_state_t;

    ingest_state_t i_state_q, i_state_d;
    egress_state_t e_state_q, e_state_d;
    logic          byte_read_q, byte_read_d;
    logic          len_read_q, len_read_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [DEPTH];

    logic push, pop, flush, flush_egress, fifo_full, mem_we;
    logic ovf_ingest, ovf_egress, can_send;

    assign fifo_full = (int'(level_q) == DEPTH);
    assign can_send  = !bus.uart_tx_busy && !tx_wr_q;

    always_comb begin
        i_state_d   = i_state_q;
        byte_read_d = 1'b0;
        push        = 1'b0;
        ovf_ingest  = 1'b0;
        if (!enable) begin
            i_state_d = I_IDLE;
        end else begin
            case (i_state_q)
                I_IDLE: begin
                    if (bus.rx_message_new_byte) begin
                        byte_read_d = 1'b1;
                        i_state_d   = I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (bus.rx_message_byte_valid) begin
                        i_state_d = I_IDLE;
                        if (fifo_full) ovf_ingest = 1'b1;
                        else           push       = 1'b1;
                    end
                end
                default: i_state_d = I_IDLE;
            endcase
        end
    end

    // Each send decision is registered, so the strobe lands the cycle after busy is seen low
    // and tx_wr_q doubles as the "strobe last cycle" gap guard.
    always_comb begin
        e_state_d    = e_state_q;
        len_read_d   = 1'b0;
        len_d        = len_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_wr_d      = 1'b0;
        pop          = 1'b0;
        ovf_egress   = 1'b0;
        flush_egress = 1'b0;
        if (!enable) begin
            e_state_d = E_IDLE;
        end else begin
            case (e_state_q)
                E_IDLE: if (bus.rx_message_length_exist) e_state_d = E_LREQ;
                E_LREQ: begin
                    len_read_d = 1'b1;
                    e_state_d  = E_LWAIT;
                end
                E_LWAIT: begin
                    if (bus.rx_message_length_valid) begin
                        len_d = bus.rx_message_length;
                        cnt_d = bus.rx_message_length;
                        if (int'(bus.rx_message_length) > DEPTH) begin
                            ovf_egress   = 1'b1;
                            flush_egress = 1'b1;
                            e_state_d    = E_IDLE;
                        end else begin
                            e_state_d = E_DWAIT;
                        end
                    end
                end
                E_DWAIT: if (int'(level_q) >= int'(len_q)) e_state_d = E_SYNC;
                E_SYNC: begin
                    if (can_send) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = SYNC_BYTE;
                        e_state_d = E_LEN;
                    end
                end
                E_LEN: begin
                    if (can_send) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = len_q;
                        e_state_d = (len_q == 8'd0) ? E_IDLE : E_DATA;
                    end
                end
                E_DATA: begin
                    if (can_send) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = mem_q[rd_ptr_q];
                        pop       = 1'b1;
                        cnt_d     = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) e_state_d = E_IDLE;
                    end
                end
                default: e_state_d = E_IDLE;
            endcase
        end
    end

    assign flush  = !enable || flush_egress;
    assign mem_we = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // A new overflow event wins over a clear arriving in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_ingest || ovf_egress) overflow_d = 1'b1;
        else if (clr_overflow)        overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_state_q   <= I_IDLE;
            e_state_q   <= E_IDLE;
            byte_read_q <= 1'b0;
            len_read_q  <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_wr_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            i_state_q   <= i_state_d;
            e_state_q   <= e_state_d;
            byte_read_q <= byte_read_d;
            len_read_q  <= len_read_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= bus.rx_message_byte;
    end

    assign bus.rx_message_byte_read   = byte_read_q;
    assign bus.rx_message_length_read = len_read_q;
    assign bus.uart_tx_data_in        = tx_data_q;
    assign bus.uart_tx_data_wr        = tx_wr_q;
    assign overflow                   = overflow_q;
    assign fifo_level                 = level_q;

endmodule
